vend_display_scan: RTL and testbench
====================================

Name: vend_display_scan

Overview:
- Downstream of the vending control FSM; consumes its price, coinBalance, change, total and alarm outputs.
- Converts each 7-bit binary field to BCD with a sequential shift-add-3 engine, one field at a time, round-robin.
- Drives an 8-digit multiplexed common-anode 7-segment display.
- Blinks the whole display while alarm is high.

Parameters:
- SCAN_DIV, 1000: clock cycles each digit stays enabled; legal range ≥1.
- BLINK_FRAMES, 100: full 8-digit scan frames per blink half-period; legal range ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- price  in  7  selected item price, binary
- coinBalance  in  7  inserted coin total, binary
- change  in  7  change owed, binary
- total  in  7  accumulated sales, binary
- alarm  in  1  insufficient-funds indication
- an_n  out  8  digit enables, active-low; bit 7 is the leftmost digit
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_n  out  1  decimal point, active-low

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - an_n=8'hFF, seg_n=7'h7F, dp_n=1.
  - All BCD shadow registers = 0.
  - Converter state LOAD, field index=0.
  - Scan counter=0, digit index=7.
  - Blink counter=0, blink phase=ON.
- Converter FSM: LOAD -> SHIFT (7 cycles) -> COMMIT -> LOAD.
  - LOAD: snapshot the selected field (0 price, 1 coinBalance, 2 change, 3 total) into the shift register; clear the 9-bit BCD accumulator (hundreds 1 bit, tens 4 bits, units 4 bits).
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1.
  - COMMIT: write the result into bcd[field]; field <= field+1 (wraps 3 -> 0).
  - 9 cycles per field; full refresh 36 cycles.
  - Input changes during SHIFT do not affect the conversion in progress (snapshot).
- Digit map:
  - price: digits 7,6; coinBalance: 5,4; change: 3,2; total: 1,0.
  - Even digit = units, odd digit = tens.
- Blanking and overflow:
  - Tens digit is blank (seg_n=7'h7F) when tens=0 and hundreds=0.
  - Units digit is always shown.
  - Hundreds=1 (value 100..127): tens digit is shown, including a '0' tens, and dp_n=0 on the tens digit.
  - dp_n=1 on all other digits.
- Scan:
  - Scan counter counts 0..SCAN_DIV-1; on wrap, digit index decrements 7 -> 0, then wraps to 7.
  - an_n is one-hot low for the current digit.
  - an_n, seg_n and dp_n are registered: one cycle latency from the index or BCD change.
- Blink:
  - While alarm=1, each digit-index wrap from 0 to 7 increments the blink counter.
  - When the counter reaches BLINK_FRAMES, it clears and the phase toggles.
  - Phase OFF forces an_n=8'hFF.
  - alarm=0 clears the counter and forces phase ON within one cycle.
  - The first OFF period starts after BLINK_FRAMES frames of alarm=1.
- Segment codes (hex, seg_n): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.

Optional Feature:
- Macro ITEM_LED_EN.
- Defined:
  - Adds input selectItem[3:0] (one-hot vended item from the control FSM) and output itemLed[3:0], active-high.
  - itemLed is selectItem registered one cycle; it is forced to 0 during blink phase OFF and reset to 0.
- Undefined: both ports are absent and no logic is generated.

Test Plan (bench uses SCAN_DIV=2, BLINK_FRAMES=2):
- Reset: rst=1 mid-run -> same cycle an_n=FF, seg_n=7F, dp_n=1. Release with all inputs 0, wait 40 cycles -> digit 0 shows seg_n=40 and digit 1 is blank (7F).
- Fields: price=5, coinBalance=12, change=7, total=0. Wait 40 cycles -> digit7=7F, digit6=12, digit5=79, digit4=24, digit3=7F, digit2=78, digit0=40.
- Overflow: total=123 -> digit1 seg_n=24 with dp_n=0, digit0 seg_n=30; total=100 -> digit1 seg_n=40 with dp_n=0, digit0 seg_n=40.
- Scan order: an_n sequence 7F, BF, DF, EF, F7, FB, FD, FE, 7F, each held 2 cycles.
- Alarm: alarm=1 -> normal display for 32 cycles, an_n=FF for 32 cycles, then normal again. Drop alarm during OFF -> next cycle an_n resumes scanning.
- Reset mid-conversion: assert rst during SHIFT with total=99, release -> field 0 is reconverted first. After 36 cycles digit1=10, digit0=10.

Source files
------------

// File: rtl/vend_display_scan.sv
// Multiplexed 8-digit 7-segment driver for the vending machine's price, coin balance, change and total.
// Optional macro ITEM_LED_EN adds the registered one-hot item LEDs (selectItem -> itemLed).
module vend_display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] price,
  input  logic [6:0] coinBalance,
  input  logic [6:0] change,
  input  logic [6:0] total,
  input  logic       alarm,
`ifdef ITEM_LED_EN
  input  logic [3:0] selectItem,
  output logic [3:0] itemLed,
`endif
  output logic [7:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {
    CV_LOAD   = 2'd0,
    CV_SHIFT  = 2'd1,
    CV_COMMIT = 2'd2
  } cv_state_e;

  cv_state_e      cv_state_q, cv_state_d;
  logic [1:0]     field_q, field_d;
  logic [6:0]     bin_q, bin_d;
  logic [8:0]     acc_q, acc_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [8:0]     bcd_q [4];
  logic           commit;
  logic [6:0]     field_val;
  logic [3:0]     units_adj, tens_adj;

  logic [SW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]     digit_q, digit_d;
  logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
  logic           phase_on_q, phase_on_d;
  logic           scan_wrap, frame_wrap, blank;
  logic [8:0]     cur_bcd;

  logic [7:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d;

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  // Shift-add-3 converter: one field per 9 cycles, snapshotted at LOAD.
  always_comb begin
    cv_state_d = cv_state_q;
    field_d    = field_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    bit_cnt_d  = bit_cnt_q;
    commit     = 1'b0;
    field_val  = price;
    case (field_q)
      2'd1:    field_val = coinBalance;
      2'd2:    field_val = change;
      2'd3:    field_val = total;
      default: field_val = price;
    endcase
    units_adj = (acc_q[3:0] >= 4'd5) ? acc_q[3:0] + 4'd3 : acc_q[3:0];
    tens_adj  = (acc_q[7:4] >= 4'd5) ? acc_q[7:4] + 4'd3 : acc_q[7:4];
    case (cv_state_q)
      CV_LOAD: begin
        bin_d      = field_val;
        acc_d      = '0;
        bit_cnt_d  = '0;
        cv_state_d = CV_SHIFT;
      end
      CV_SHIFT: begin
        {acc_d, bin_d} = {acc_q[8], tens_adj, units_adj, bin_q} << 1;
        bit_cnt_d      = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd6) cv_state_d = CV_COMMIT;
      end
      CV_COMMIT: begin
        commit     = 1'b1;
        field_d    = field_q + 2'd1;
        cv_state_d = CV_LOAD;
      end
      default: cv_state_d = CV_LOAD;
    endcase
  end

  // Scan, blink and registered display outputs. Digit 7..6 map to field 0, so field = ~digit[2:1].
  always_comb begin
    scan_wrap   = (scan_cnt_q == SW'(SCAN_DIV - 1));
    frame_wrap  = scan_wrap && (digit_q == 3'd0);
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SW'(1);
    digit_d     = scan_wrap ? digit_q - 3'd1 : digit_q;
    blink_cnt_d = blink_cnt_q;
    phase_on_d  = phase_on_q;
    if (!alarm) begin
      blink_cnt_d = '0;
      phase_on_d  = 1'b1;
    end else if (frame_wrap) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_on_d  = ~phase_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
    blank   = alarm && !phase_on_q;
    cur_bcd = bcd_q[~digit_q[2:1]];
    an_d    = blank ? 8'hFF : ~(8'd1 << digit_q);
    seg_d   = seg_code(cur_bcd[3:0]);
    dp_d    = 1'b1;
    if (digit_q[0]) begin
      seg_d = (cur_bcd[8] || (cur_bcd[7:4] != 4'd0)) ? seg_code(cur_bcd[7:4]) : 7'h7F;
      dp_d  = ~cur_bcd[8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cv_state_q  <= CV_LOAD;
      field_q     <= '0;
      bin_q       <= '0;
      acc_q       <= '0;
      bit_cnt_q   <= '0;
      for (int i = 0; i < 4; i++) bcd_q[i] <= '0;
      scan_cnt_q  <= '0;
      digit_q     <= 3'd7;
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b1;
      an_q        <= 8'hFF;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      cv_state_q  <= cv_state_d;
      field_q     <= field_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      bit_cnt_q   <= bit_cnt_d;
      if (commit) bcd_q[field_q] <= acc_q;
      scan_cnt_q  <= scan_cnt_d;
      digit_q     <= digit_d;
      blink_cnt_q <= blink_cnt_d;
      phase_on_q  <= phase_on_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an_n  = an_q;
  assign seg_n = seg_q;
  assign dp_n  = dp_q;

`ifdef ITEM_LED_EN
  logic [3:0] item_led_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) item_led_q <= '0;
    else     item_led_q <= blank ? 4'd0 : selectItem;
  end
  assign itemLed = item_led_q;
`endif

endmodule

// File: tb/tb_vend_display_scan.sv
// Bench for vend_display_scan: fixed vectors, multi-cycle corner sequences and a per-cycle reference model.
module tb_vend_display_scan;
  localparam int S  = 2;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] price = '0, coinBalance = '0, change = '0, total = '0;
  logic       alarm = 1'b0;
  logic [7:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  vend_display_scan #(.SCAN_DIV(S), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .price(price), .coinBalance(coinBalance),
    .change(change), .total(total), .alarm(alarm),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (time arithmetic since reset) ----------------
  logic [6:0] code_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int         cyc, m_d, m_f, m_v, fc;
  int         disp [4];
  int         snap [4];
  bit         off, chk_en = 1'b0;
  logic [7:0] m_an;
  logic [6:0] m_seg;
  logic       m_dp;

  function automatic int input_field(input int f);
    case (f)
      0:       return int'(price);
      1:       return int'(coinBalance);
      2:       return int'(change);
      default: return int'(total);
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; fc = 0; off = 1'b0;
      for (int i = 0; i < 4; i++) begin disp[i] = 0; snap[i] = 0; end
      m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
    end else begin
      cyc++;
      m_d  = 7 - ((cyc - 1) / S) % 8;
      m_f  = 3 - m_d / 2;
      m_v  = disp[m_f];
      m_an = (alarm && off) ? 8'hFF : ~(8'd1 << m_d);
      if (m_d % 2 == 0) begin
        m_seg = code_tbl[m_v % 10]; m_dp = 1'b1;
      end else if (m_v < 10) begin
        m_seg = 7'h7F; m_dp = 1'b1;
      end else begin
        m_seg = code_tbl[(m_v / 10) % 10]; m_dp = (m_v < 100);
      end
      if ((cyc - 1) % 9 == 0) snap[((cyc - 1) / 9) % 4] = input_field(((cyc - 1) / 9) % 4);
      if (cyc % 9 == 0) disp[(cyc / 9 - 1) % 4] = snap[(cyc / 9 - 1) % 4];
      if (!alarm) begin
        fc = 0; off = 1'b0;
      end else if (cyc % (8 * S) == 0) begin
        fc++;
        if (fc == BF) begin fc = 0; off = !off; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model an_n", an_n, m_an);
      check("model seg_n", {1'b0, seg_n}, {1'b0, m_seg});
      check("model dp_n", {7'd0, dp_n}, {7'd0, m_dp});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_point();
    @(negedge clk);
    #2;
  endtask

  task automatic set_in(input logic [6:0] p, input logic [6:0] c, input logic [6:0] ch, input logic [6:0] t);
    price = p; coinBalance = c; change = ch; total = t;
  endtask

  task automatic do_reset();
    drive_point();
    rst = 1'b1;
    #1;
    check("reset an_n", an_n, 8'hFF);
    check("reset seg_n", {1'b0, seg_n}, 8'h7F);
    check("reset dp_n", {7'd0, dp_n}, 8'h01);
    drive_point();
    rst = 1'b0;
  endtask

  task automatic find_digit(input int d);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (an_n == ~(8'd1 << d)) ok = 1'b1;
    end
    checks++;
    if (ok) passes++;
    else $display("FAIL find digit %0d: an_n stuck at %h", d, an_n);
  endtask

  typedef struct {
    logic [6:0] p, c, ch, t;
    int         d;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  vec_t       vecs [20];
  logic [7:0] seq [9];

  initial begin
    vecs[0]  = '{7'd0,   7'd0,  7'd0,  7'd0,   0, 7'h40, 1'b1};
    vecs[1]  = '{7'd0,   7'd0,  7'd0,  7'd0,   1, 7'h7F, 1'b1};
    vecs[2]  = '{7'd5,   7'd12, 7'd7,  7'd0,   7, 7'h7F, 1'b1};
    vecs[3]  = '{7'd5,   7'd12, 7'd7,  7'd0,   6, 7'h12, 1'b1};
    vecs[4]  = '{7'd5,   7'd12, 7'd7,  7'd0,   5, 7'h79, 1'b1};
    vecs[5]  = '{7'd5,   7'd12, 7'd7,  7'd0,   4, 7'h24, 1'b1};
    vecs[6]  = '{7'd5,   7'd12, 7'd7,  7'd0,   3, 7'h7F, 1'b1};
    vecs[7]  = '{7'd5,   7'd12, 7'd7,  7'd0,   2, 7'h78, 1'b1};
    vecs[8]  = '{7'd5,   7'd12, 7'd7,  7'd0,   0, 7'h40, 1'b1};
    vecs[9]  = '{7'd5,   7'd12, 7'd7,  7'd123, 1, 7'h24, 1'b0};
    vecs[10] = '{7'd5,   7'd12, 7'd7,  7'd123, 0, 7'h30, 1'b1};
    vecs[11] = '{7'd5,   7'd12, 7'd7,  7'd100, 1, 7'h40, 1'b0};
    vecs[12] = '{7'd5,   7'd12, 7'd7,  7'd100, 0, 7'h40, 1'b1};
    vecs[13] = '{7'd127, 7'd99, 7'd10, 7'd9,   7, 7'h24, 1'b0};
    vecs[14] = '{7'd127, 7'd99, 7'd10, 7'd9,   6, 7'h78, 1'b1};
    vecs[15] = '{7'd127, 7'd99, 7'd10, 7'd9,   5, 7'h10, 1'b1};
    vecs[16] = '{7'd127, 7'd99, 7'd10, 7'd9,   3, 7'h79, 1'b1};
    vecs[17] = '{7'd127, 7'd99, 7'd10, 7'd9,   2, 7'h40, 1'b1};
    vecs[18] = '{7'd127, 7'd99, 7'd10, 7'd9,   1, 7'h7F, 1'b1};
    vecs[19] = '{7'd127, 7'd99, 7'd10, 7'd9,   0, 7'h10, 1'b1};
    seq = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'h7F};

    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);

    // reset mid-run, then the fixed vector table
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive_point();
      set_in(vecs[i].p, vecs[i].c, vecs[i].ch, vecs[i].t);
      repeat (48) @(negedge clk);
      find_digit(vecs[i].d);
      check($sformatf("vec%0d seg_n", i), {1'b0, seg_n}, {1'b0, vecs[i].seg});
      check($sformatf("vec%0d dp_n", i), {7'd0, dp_n}, {7'd0, vecs[i].dp});
    end

    // scan order from reset release
    do_reset();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check($sformatf("scan step %0d", i), an_n, seq[i / 2]);
    end

    // blink: 32 cycles on, 32 off, on again; drop alarm during the second OFF
    alarm = 1'b1;
    do_reset();
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n <= 72) check($sformatf("blink off cyc %0d", n), {7'd0, an_n == 8'hFF}, {7'd0, (n >= 33 && n <= 64)});
      if (n == 100) check("blink second off", an_n, 8'hFF);
    end
    #2 alarm = 1'b0;
    @(negedge clk);
    check("alarm drop resume", an_n, 8'hDF);

    // reset during the SHIFT of the total field
    drive_point();
    set_in(7'd0, 7'd0, 7'd0, 7'd99);
    do_reset();
    repeat (30) @(negedge clk);
    do_reset();
    repeat (14) @(negedge clk);
    find_digit(0);
    check("midconv total not yet", {1'b0, seg_n}, 8'h40);
    repeat (22) @(negedge clk);
    find_digit(1);
    check("midconv tens", {1'b0, seg_n}, 8'h10);
    find_digit(0);
    check("midconv units", {1'b0, seg_n}, 8'h10);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive_point();
      if (rst) rst = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       price       = 7'($urandom_range(0, 127));
          1:       coinBalance = 7'($urandom_range(0, 127));
          2:       change      = 7'($urandom_range(0, 127));
          default: total       = 7'($urandom_range(0, 127));
        endcase
      end
      if ($urandom_range(0, 99) == 0) alarm = ~alarm;
      if ($urandom_range(0, 799) == 0) rst = 1'b1;
    end
    drive_point();
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
